// File: rtl/cmos_nand_counter_pkg.sv
// Shared constants for the switch-level counter library: default width,
// legal width range and the reference clock half-period used by benches.
package cmos_nand_counter_pkg;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int MIN_WIDTH       = 2;
    localparam int MAX_WIDTH       = 8;
    localparam int CLK_HALF_PERIOD = 5;

endpackage

// File: rtl/cmos_nand_counter_if.sv
// Counter-side signal bundle: count enable in, count value and terminal count out.
interface cmos_nand_counter_if
    import cmos_nand_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             en;
    logic [WIDTH-1:0] q;
    logic             tc;

    modport master (output en, input q, input tc);
    modport slave  (input en, output q, output tc);

endinterface

// File: rtl/cmos_dff_clr.sv
// Positive-edge D flip-flop in the 7474 six-NAND form with active-low clear.
// The preset leg of every 3-input NAND is tied high, so only clear is usable.
module cmos_dff_clr (
    input  wire clk,
    input  wire clr_n,
    input  wire d,
    output wire q,
    output wire qn
);

    supply1 vdd;
    wire    n1;
    wire    n2;
    wire    n3;
    wire    n4;

    // Input latches: n2/n3 only move while clk is high and are then locked,
    // so d changes after the edge cannot reach the output latch.
    cmos_nand3 u_n1 (.a(vdd), .b(n4),    .c(n2),  .y(n1));
    cmos_nand3 u_n2 (.a(n1),  .b(clr_n), .c(clk), .y(n2));
    cmos_nand3 u_n3 (.a(n2),  .b(clk),   .c(n4),  .y(n3));
    cmos_nand3 u_n4 (.a(n3),  .b(clr_n), .c(d),   .y(n4));

    cmos_nand3 u_q  (.a(vdd), .b(n2),    .c(qn),  .y(q));
    cmos_nand3 u_qn (.a(q),   .b(n3),    .c(clr_n), .y(qn));

endmodule

// File: rtl/cmos_nand2.sv
// Switch-level 2-input NAND: two parallel pmos pull-ups, two series nmos pull-downs.
module cmos_nand2 (
    input  wire a,
    input  wire b,
    output wire y
);

    supply1 vdd;
    supply0 gnd;
    wire    mid;

    pmos p_a (y, vdd, a);
    pmos p_b (y, vdd, b);
    nmos n_a (y, mid, a);
    nmos n_b (mid, gnd, b);

endmodule

// File: rtl/cmos_nand3.sv
// Switch-level 3-input NAND: three parallel pmos pull-ups, three series nmos pull-downs.
module cmos_nand3 (
    input  wire a,
    input  wire b,
    input  wire c,
    output wire y
);

    supply1 vdd;
    supply0 gnd;
    wire    mid_ab;
    wire    mid_bc;

    pmos p_a (y, vdd, a);
    pmos p_b (y, vdd, b);
    pmos p_c (y, vdd, c);
    nmos n_a (y, mid_ab, a);
    nmos n_b (mid_ab, mid_bc, b);
    nmos n_c (mid_bc, gnd, c);

endmodule

// File: rtl/cmos_nand_counter.sv
// WIDTH-bit synchronous up-counter made only of NAND cells: one flip-flop plus
// one carry/XOR slice per bit, with terminal count taken from the last carry.
module cmos_nand_counter
    import cmos_nand_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire                 clk,
    input  wire                 rst_n,
    cmos_nand_counter_if.slave  bus
);

    wire [WIDTH:0]   carry;
    wire [WIDTH-1:0] q_bit;
    wire [WIDTH-1:0] d_bit;
    wire [WIDTH-1:0] qn_unused;

    assign carry[0] = bus.en;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        wire carry_n;
        wire xor_q;
        wire xor_c;

        // carry_n doubles as the first gate of the 4-NAND XOR.
        cmos_nand2 u_and_nand (.a(carry[gi]), .b(q_bit[gi]), .y(carry_n));
        cmos_nand2 u_and_inv  (.a(carry_n),   .b(carry_n),   .y(carry[gi+1]));

        cmos_nand2 u_xor_q    (.a(q_bit[gi]), .b(carry_n),   .y(xor_q));
        cmos_nand2 u_xor_c    (.a(carry[gi]), .b(carry_n),   .y(xor_c));
        cmos_nand2 u_xor_out  (.a(xor_q),     .b(xor_c),     .y(d_bit[gi]));

        cmos_dff_clr u_ff (
            .clk   (clk),
            .clr_n (rst_n),
            .d     (d_bit[gi]),
            .q     (q_bit[gi]),
            .qn    (qn_unused[gi])
        );
    end

    assign bus.q  = q_bit;
    assign bus.tc = carry[WIDTH];

endmodule

// File: tb/tb_cmos_nand_counter.sv
// Bench for the NAND-level counter: a 4-bit and a 3-bit instance on one clock,
// vector tables, hand-written corner sequences and a randomized run.
module tb_cmos_nand_counter;
    import cmos_nand_counter_pkg::*;

    logic clk;
    logic rst_n;

    cmos_nand_counter_if #(.WIDTH(4)) bus4 ();
    cmos_nand_counter_if #(.WIDTH(3)) bus3 ();

    cmos_nand_counter #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    cmos_nand_counter #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    int checks = 0;
    int errors = 0;

    // Reference: a modulo counter per instance, cleared whenever reset is low.
    int model4 = 0;
    int model3 = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model4 <= 0;
            model3 <= 0;
        end else begin
            if (bus4.en) model4 <= (model4 + 1) % 16;
            if (bus3.en) model3 <= (model3 + 1) % 8;
        end
    end

    typedef struct packed {
        logic       en;
        logic [3:0] q;
        logic       tc;
    } vec_t;

    vec_t vecs[$];

    initial begin
        clk = 1'b0;
        forever #CLK_HALF_PERIOD clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_models(input string tag);
        check({tag, "_q4"},  8'(bus4.q),  8'(model4));
        check({tag, "_tc4"}, 8'(bus4.tc), 8'(bus4.en && model4 == 15));
        check({tag, "_q3"},  8'(bus3.q),  8'(model3));
        check({tag, "_tc3"}, 8'(bus3.tc), 8'(bus3.en && model3 == 7));
    endtask

    initial begin
        vec_t v;
        int   seq3[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

        // Steady count 1..15 then wrap, then up to 5, hold 3 edges, resume.
        for (int i = 1; i <= 16; i++) begin
            v.en = 1'b1; v.q = 4'(i % 16); v.tc = (i == 15); vecs.push_back(v);
        end
        for (int i = 1; i <= 5; i++) begin
            v.en = 1'b1; v.q = 4'(i); v.tc = 1'b0; vecs.push_back(v);
        end
        for (int i = 0; i < 3; i++) begin
            v.en = 1'b0; v.q = 4'd5; v.tc = 1'b0; vecs.push_back(v);
        end
        v.en = 1'b1; v.q = 4'd6; v.tc = 1'b0; vecs.push_back(v);

        // Reset window with en high and the clock running.
        rst_n   = 1'b0;
        bus4.en = 1'b1;
        bus3.en = 1'b1;
        #1;
        check("rst_q_t1",  8'(bus4.q),  8'd0);
        check("rst_tc_t1", 8'(bus4.tc), 8'd0);
        check("rst_x_t1",  8'($isunknown(bus4.q)), 8'd0);
        #6;
        check("rst_q_t7",  8'(bus4.q),  8'd0);
        check("rst_q3_t7", 8'(bus3.q),  8'd0);
        #4;
        check("rst_q_t11",  8'(bus4.q),  8'd0);
        check("rst_tc_t11", 8'(bus4.tc), 8'd0);
        #1;
        rst_n   = 1'b1;
        bus3.en = 1'b0;
        $display("txn release t=%0t", $time);

        foreach (vecs[k]) begin
            bus4.en = vecs[k].en;
            step();
            check("vec_q",  8'(bus4.q),  8'(vecs[k].q));
            check("vec_tc", 8'(bus4.tc), 8'(vecs[k].tc));
            $display("txn vec %0d en=%b q=%0d tc=%b", k, vecs[k].en, bus4.q, bus4.tc);
        end

        // Count up to all ones, then probe en pulses that avoid every edge.
        bus4.en = 1'b1;
        repeat (9) step();
        check("ones_q",  8'(bus4.q),  8'd15);
        check("ones_tc", 8'(bus4.tc), 8'd1);
        bus4.en = 1'b0;
        #1;
        check("ones_en0_tc", 8'(bus4.tc), 8'd0);
        #1 bus4.en = 1'b1;
        #1;
        check("pulse_tc", 8'(bus4.tc), 8'd1);
        bus4.en = 1'b0;
        #4 bus4.en = 1'b1;
        #1 bus4.en = 1'b0;
        step();
        check("pulse_hold_q", 8'(bus4.q),  8'd15);
        check("pulse_hold_tc", 8'(bus4.tc), 8'd0);
        $display("txn pulse q=%0d tc=%b", bus4.q, bus4.tc);

        // Reach 1010, then assert reset between edges.
        bus4.en = 1'b1;
        repeat (11) step();
        check("pre_rst_q", 8'(bus4.q), 8'd10);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_q",  8'(bus4.q),  8'd0);
        check("async_rst_tc", 8'(bus4.tc), 8'd0);
        step();
        check("rst_hold_q", 8'(bus4.q), 8'd0);
        #2 rst_n = 1'b1;
        step();
        check("post_rst_q", 8'(bus4.q), 8'd1);
        $display("txn midreset q=%0d", bus4.q);

        // 3-bit instance from a fresh reset.
        bus4.en = 1'b0;
        rst_n   = 1'b0;
        #2 rst_n = 1'b1;
        bus3.en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            check("w3_q",  8'(bus3.q),  8'(seq3[i]));
            check("w3_tc", 8'(bus3.tc), 8'(seq3[i] == 7));
            $display("txn w3 %0d q=%0d tc=%b", i, bus3.q, bus3.tc);
        end
        check("w3_q4_idle", 8'(bus4.q), 8'd0);

        // Randomized enables with occasional mid-period resets.
        for (int i = 0; i < 300; i++) begin
            bus4.en = 1'($urandom_range(0, 1));
            bus3.en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                #2 rst_n = 1'b0;
                #1 check_models("rnd_rst");
                #1 rst_n = 1'b1;
            end
            #1 check_models("rnd_comb");
            step();
            check_models("rnd");
            $display("txn rnd %0d en4=%b q4=%0d en3=%b q3=%0d", i, bus4.en, bus4.q, bus3.en, bus3.q);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
